// File: rtl/bch_decoder_seq_if.sv
// Handshake bundle for the sequential t=2 BCH decoder.
// master = upstream/downstream driver side, slave = decoder side.
interface bch_decoder_seq_if #(
   parameter int N = 31
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] codeword_i;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] corrected_o;
   logic [1:0]   err_count_o;
   logic         uncorrectable_o;

   modport master (
      output in_valid, codeword_i, out_ready,
      input  in_ready, out_valid, corrected_o,
      input  err_count_o, uncorrectable_o
   );

   modport slave (
      input  in_valid, codeword_i, out_ready,
      output in_ready, out_valid, corrected_o,
      output err_count_o, uncorrectable_o
   );
endinterface

// File: rtl/bch_decoder_seq.sv
// Sequential t=2 binary BCH decoder over GF(2^M).
// Bit-serial syndromes, closed-form locator, serial Chien search.
module bch_decoder_seq #(
   parameter int             M         = 5,
   parameter int             N         = 31,
   parameter logic [M-1:0]   PRIM_POLY = 5'h05
) (
   input logic               clk,
   input logic               rst,
   bch_decoder_seq_if.slave  bus
);

   localparam int CW = $clog2(N);

   typedef enum logic [2:0] {
      IDLE, SYND, KEY, CHIEN, DONE
   } state_t;

   state_t        state;
   logic [N-1:0]  raw;
   logic [N-1:0]  mask;
   logic [N-1:0]  corr_q;
   logic [M-1:0]  s1, s3;
   logic [M-1:0]  t0, t1, t2;
   logic [CW-1:0] cnt;
   logic [1:0]    deg, roots, err_q;
   logic          unc_syn, unc_q;
   logic          in_ready_q, out_valid_q;

   logic          hit;
   logic [N-1:0]  mask_nx;
   logic [1:0]    roots_nx;
   logic          fail_nx;
   logic [M-1:0]  s1_sq, s1_cu, l2;

   function automatic logic [M-1:0] mul_a(
      input logic [M-1:0] x
   );
      return {x[M-2:0], 1'b0} ^
             (x[M-1] ? PRIM_POLY : '0);
   endfunction

   // Multiply by alpha^-1: fold the polynomial back in when bit 0 is set.
   function automatic logic [M-1:0] div_a(
      input logic [M-1:0] x
   );
      logic [M-1:0] y;
      y = x ^ PRIM_POLY;
      return x[0] ? {1'b1, y[M-1:1]}
                  : {1'b0, x[M-1:1]};
   endfunction

   function automatic logic [M-1:0] gf_mul(
      input logic [M-1:0] a,
      input logic [M-1:0] b
   );
      logic [M-1:0] r;
      r = '0;
      for (int k = M - 1; k >= 0; k--) begin
         r = mul_a(r) ^ (b[k] ? a : '0);
      end
      return r;
   endfunction

   always_comb begin
      hit      = (t0 ^ t1 ^ t2) == '0;
      mask_nx  = mask |
                 ({{(N-1){1'b0}}, hit} << cnt);
      roots_nx = roots;
      if (hit && roots != 2'd3) begin
         roots_nx = roots + 2'd1;
      end
      fail_nx  = unc_syn | (roots_nx != deg);
      s1_sq    = gf_mul(s1, s1);
      s1_cu    = gf_mul(s1_sq, s1);
      l2       = s3 ^ s1_cu;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         raw         <= '0;
         mask        <= '0;
         corr_q      <= '0;
         s1          <= '0;
         s3          <= '0;
         t0          <= '0;
         t1          <= '0;
         t2          <= '0;
         cnt         <= '0;
         deg         <= '0;
         roots       <= '0;
         err_q       <= '0;
         unc_syn     <= 1'b0;
         unc_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  raw        <= bus.codeword_i;
                  s1         <= '0;
                  s3         <= '0;
                  cnt        <= CW'(N - 1);
                  in_ready_q <= 1'b0;
                  state      <= SYND;
               end
            end
            SYND: begin
               s1 <= mul_a(s1) ^
                     {{(M-1){1'b0}}, raw[cnt]};
               s3 <= mul_a(mul_a(mul_a(s3))) ^
                     {{(M-1){1'b0}}, raw[cnt]};
               if (cnt == '0) begin
                  state <= KEY;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            KEY: begin
               unique case (1'b1)
                  (s1 == '0 && s3 == '0): begin
                     t0      <= M'(1);
                     t1      <= '0;
                     t2      <= '0;
                     deg     <= 2'd0;
                     unc_syn <= 1'b0;
                  end
                  (s1 == '0 && s3 != '0): begin
                     t0      <= M'(1);
                     t1      <= '0;
                     t2      <= '0;
                     deg     <= 2'd0;
                     unc_syn <= 1'b1;
                  end
                  default: begin
                     t0      <= s1;
                     t1      <= s1_sq;
                     t2      <= l2;
                     deg     <= (l2 == '0) ? 2'd1 : 2'd2;
                     unc_syn <= 1'b0;
                  end
               endcase
               mask  <= '0;
               roots <= '0;
               cnt   <= '0;
               state <= CHIEN;
            end
            CHIEN: begin
               t1    <= div_a(t1);
               t2    <= div_a(div_a(t2));
               mask  <= mask_nx;
               roots <= roots_nx;
               if (cnt == CW'(N - 1)) begin
                  corr_q      <= fail_nx ? raw : raw ^ mask_nx;
                  err_q       <= fail_nx ? 2'd0 : deg;
                  unc_q       <= fail_nx;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready        = in_ready_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.corrected_o     = corr_q;
   assign bus.err_count_o     = err_q;
   assign bus.uncorrectable_o = unc_q;

endmodule

// File: tb/tb_bch_decoder_seq.sv
// Randomised bench for bch_decoder_seq against a brute-force
// nearest-codeword model over GF(32).
module tb_bch_decoder_seq;

   localparam int           M    = 5;
   localparam int           N    = 31;
   localparam logic [M-1:0] PRIM = 5'h05;
   localparam int           Q    = (1 << M) - 1;
   localparam int           LAT  = 2 * N + 2;

   typedef struct packed {
      logic [N-1:0] corr;
      logic [1:0]   cnt;
      logic         unc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bch_decoder_seq_if #(.N(N)) bus();

   bch_decoder_seq #(
      .M(M), .N(N), .PRIM_POLY(PRIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int   checks = 0;
   int   errors = 0;
   int   gexp[0:Q-1];
   int   sj[0:N-1];
   int   low_tab[0:1023];
   exp_t exp_q[$];

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h",
                  nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Syndrome pair packed as {S1,S3}, from power sums of alpha.
   function automatic int syn(input logic [N-1:0] w);
      int a = 0;
      int b = 0;
      for (int i = 0; i < N; i++) begin
         if (w[i]) begin
            a ^= gexp[i % Q];
            b ^= gexp[(3 * i) % Q];
         end
      end
      return (a << M) | b;
   endfunction

   // Nearest codeword within distance 2, else uncorrectable.
   function automatic exp_t model(input logic [N-1:0] w);
      exp_t r;
      int   s;
      logic found;
      s     = syn(w);
      r     = '{corr: w, cnt: 2'd0, unc: 1'b0};
      found = (s == 0);
      for (int j = 0; j < N && !found; j++) begin
         if (sj[j] == s) begin
            r.corr    = w;
            r.corr[j] = ~w[j];
            r.cnt     = 2'd1;
            found     = 1'b1;
         end
      end
      for (int j = 0; j < N && !found; j++) begin
         for (int k = j + 1; k < N && !found; k++) begin
            if ((sj[j] ^ sj[k]) == s) begin
               r.corr    = w;
               r.corr[j] = ~w[j];
               r.corr[k] = ~w[k];
               r.cnt     = 2'd2;
               found     = 1'b1;
            end
         end
      end
      if (!found) r.unc = 1'b1;
      return r;
   endfunction

   function automatic logic [N-1:0] mk_cw();
      logic [N-1:0] w;
      w = N'($urandom) & ~N'(32'h3FF);
      return w | N'(low_tab[syn(w)]);
   endfunction

   // Compare process: every valid cycle must match the queued result.
   always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
         end else begin
            chk("corrected", bus.corrected_o, exp_q[0].corr);
            chk("err_count", bus.err_count_o, exp_q[0].cnt);
            chk("uncorr", bus.uncorrectable_o, exp_q[0].unc);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input  logic [N-1:0] w,
                       input  int           hold,
                       input  int           rst_at,
                       output exp_t         got);
      int n;
      got = '0;
      n   = 0;
      while (!bus.in_ready && n < 300) begin
         tick();
         n++;
      end
      chk("in_ready_wait", bus.in_ready, 1);
      exp_q.push_back(model(w));
      bus.in_valid   = 1'b1;
      bus.codeword_i = w;
      tick();
      n = 1;
      while (!bus.out_valid && n < LAT + 20) begin
         bus.in_valid   = 1'($urandom_range(0, 1));
         bus.codeword_i = N'($urandom);
         if (rst_at != 0 && n == rst_at) begin
            rst = 1'b1;
            tick();
            rst          = 1'b0;
            bus.in_valid = 1'b0;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_corrected", bus.corrected_o, 0);
            chk("rst_err_count", bus.err_count_o, 0);
            chk("rst_uncorr", bus.uncorrectable_o, 0);
            void'(exp_q.pop_back());
            return;
         end
         tick();
         n++;
      end
      chk("latency", n, LAT);
      got = '{corr: bus.corrected_o,
              cnt: bus.err_count_o,
              unc: bus.uncorrectable_o};
      for (int h = 0; h < hold; h++) begin
         bus.in_valid   = 1'b1;
         bus.codeword_i = N'($urandom);
         chk("hold_in_ready", bus.in_ready, 0);
         chk("hold_out_valid", bus.out_valid, 1);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("release_out_valid", bus.out_valid, 0);
      chk("release_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      exp_t         g, e;
      logic [N-1:0] c, w;
      int           x, p;

      x = 1;
      for (int i = 0; i < Q; i++) begin
         gexp[i] = x;
         x = x << 1;
         if ((x >> M) & 1) x = (x ^ (1 << M)) ^ int'(PRIM);
      end
      for (int j = 0; j < N; j++) begin
         sj[j] = (gexp[j] << M) | gexp[(3 * j) % Q];
      end
      for (int i = 0; i < 1024; i++) low_tab[i] = 0;
      for (int i = 0; i < 1024; i++) low_tab[syn(N'(i))] = i;

      // Hand-derived anchors for the model: a^5=a^2+1, a^10=a^4+1.
      chk("model_a5", gexp[5], 5);
      chk("model_a10", gexp[10], 17);
      chk("model_syn_bit1", sj[1], 72);
      e = model(N'(32'h20));
      chk("model_single", {e.corr, e.cnt, e.unc}, {31'h0, 2'd1, 1'b0});
      e = model(N'(32'h40000001));
      chk("model_double", {e.corr, e.cnt, e.unc}, {31'h0, 2'd2, 1'b0});

      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.codeword_i = '0;
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_corrected", bus.corrected_o, 0);
      chk("reset_err_count", bus.err_count_o, 0);
      chk("reset_uncorr", bus.uncorrectable_o, 0);
      rst = 1'b0;
      tick();

      send('0, 0, 0, g);
      chk("zero_word", {g.corr, g.cnt, g.unc}, {31'h0, 2'd0, 1'b0});

      c = mk_cw();
      chk("cw_syndrome", syn(c), 0);
      w = c;
      w[5] = ~w[5];
      send(w, 0, 0, g);
      chk("single_bit5", {g.corr, g.cnt, g.unc}, {c, 2'd1, 1'b0});

      c = mk_cw();
      w = c;
      w[0]  = ~w[0];
      w[30] = ~w[30];
      send(w, 0, 0, g);
      chk("double_0_30", {g.corr, g.cnt, g.unc}, {c, 2'd2, 1'b0});

      for (int j = 0; j < N; j++) begin
         for (int k = j + 1; k < N; k++) begin
            w = '0;
            w[j] = 1'b1;
            w[k] = 1'b1;
            send(w, 0, 0, g);
            chk("pair", {g.corr, g.cnt, g.unc}, {31'h0, 2'd2, 1'b0});
         end
      end

      w = N'(32'h7);
      send(w, 0, 0, g);
      chk("triple_012",
          (g.unc && g.corr == w && g.cnt == 2'd0) ||
          (!g.unc && $countones(g.corr ^ w) <= 2 &&
           syn(g.corr) == 0),
          1);

      c = mk_cw();
      w = c;
      w[12] = ~w[12];
      send(w, 10, 0, g);
      chk("held_result", {g.corr, g.cnt, g.unc}, {c, 2'd1, 1'b0});

      send(mk_cw(), 0, 40, g);
      c = mk_cw();
      w = c;
      w[3]  = ~w[3];
      w[17] = ~w[17];
      send(w, 0, 0, g);
      chk("after_reset", {g.corr, g.cnt, g.unc}, {c, 2'd2, 1'b0});

      for (int r = 0; r < 40; r++) begin
         c = mk_cw();
         w = c;
         p = $urandom_range(0, 4);
         for (int b = 0; b < p; b++) begin
            x = $urandom_range(0, N - 1);
            w[x] = ~w[x];
         end
         send(w, $urandom_range(0, 3), 0, g);
      end

      repeat (4) tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
